fsm_code_decoder: RTL and testbench

- Receive-side counterpart of the 3-bit state-code sequence generator (codes q0=2, q1=6, q2=4, q3=7, q4=1).
- Observes the generator's 3-bit output stream and checks every code and every transition against the generator's transition table.
- Reconstructs the input bit `a` whenever a transition determines it, and acquires/loses lock based on stream legality.
- Sits downstream of the generator as a link monitor and bit recoverer.

---
 rtl/fsm_code_decoder.sv | 190 +++++++++++++++++++
 tb/tb_fsm_code_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fsm_code_decoder.sv
// Link monitor and bit recoverer for the 3-bit state-code stream.
// Checks codes/transitions, tracks lock, and rebuilds the input bit.
module fsm_code_decoder #(
    parameter int LOCK_CNT = 3,
    parameter int SHIFT_W  = 8,
    parameter int ERR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [2:0]         code,
    output logic               bit_valid,
    output logic               bit_out,
    output logic [SHIFT_W-1:0] shift_reg,
    output logic [7:0]         bit_count,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

    state_t     state, state_n;
    logic [2:0] prev_code, prev_n;
    logic [3:0] lc, lc_n;
    logic [3:0] lc_inc;

    logic code_ok;
    logic t_legal;
    logic t_dec;
    logic t_bit;

    logic bv_n;
    logic bo_n;
    logic ep_n;
    logic push;

    assign lc_inc = lc + 4'd1;

    // Classify the incoming code against the generator's code set.
    always_comb begin
        code_ok = 1'b0;
        case (code)
            3'd1, 3'd2, 3'd4, 3'd6, 3'd7: code_ok = 1'b1;
            default:                      code_ok = 1'b0;
        endcase
    end

    // Look up the previous->current transition and any bit it carries.
    always_comb begin
        t_legal = 1'b0;
        t_dec   = 1'b0;
        t_bit   = 1'b0;
        case ({prev_code, code})
            {3'd2, 3'd4},
            {3'd6, 3'd7},
            {3'd1, 3'd6}: begin
                t_legal = 1'b1;
            end
            {3'd4, 3'd6},
            {3'd7, 3'd2}: begin
                t_legal = 1'b1;
                t_dec   = 1'b1;
                t_bit   = 1'b1;
            end
            {3'd4, 3'd1},
            {3'd7, 3'd4}: begin
                t_legal = 1'b1;
                t_dec   = 1'b1;
                t_bit   = 1'b0;
            end
            default: begin
                t_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic: lock acquisition, error detection, bit emission.
    always_comb begin
        state_n = state;
        prev_n  = prev_code;
        lc_n    = lc;
        bv_n    = 1'b0;
        bo_n    = bit_out;
        ep_n    = 1'b0;
        push    = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (code_ok) begin
                        prev_n  = code;
                        lc_n    = 4'd0;
                        state_n = TRACK;
                    end else begin
                        ep_n = 1'b1;
                    end
                end
                TRACK: begin
                    if (!code_ok) begin
                        ep_n    = 1'b1;
                        state_n = IDLE;
                    end else if (!t_legal) begin
                        ep_n   = 1'b1;
                        prev_n = code;
                        lc_n   = 4'd0;
                    end else begin
                        prev_n = code;
                        lc_n   = lc_inc;
                        if (lc_inc == LOCK_MAX) begin
                            state_n = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!code_ok) begin
                        ep_n    = 1'b1;
                        state_n = IDLE;
                    end else if (!t_legal) begin
                        ep_n    = 1'b1;
                        prev_n  = code;
                        lc_n    = 4'd0;
                        state_n = TRACK;
                    end else begin
                        prev_n = code;
                        if (t_dec) begin
                            bv_n = 1'b1;
                            bo_n = t_bit;
                            push = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Control state: FSM, previous code and lock counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prev_code <= 3'd0;
            lc        <= 4'd0;
        end else begin
            state     <= state_n;
            prev_code <= prev_n;
            lc        <= lc_n;
        end
    end

    // Registered bit outputs; history survives lock loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            shift_reg <= '0;
            bit_count <= 8'd0;
        end else begin
            bit_valid <= bv_n;
            bit_out   <= bo_n;
            if (push) begin
                shift_reg <= {shift_reg[SHIFT_W-2:0], bo_n};
                bit_count <= bit_count + 8'd1;
            end
        end
    end

    // Error pulse and saturating error total.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= ep_n;
            if (ep_n && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_fsm_code_decoder.sv
// Scoreboard bench for fsm_code_decoder: directed code stream,
// expected outputs queued by the driver and checked by a monitor.
module tb_fsm_code_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] code;
    logic       in_valid2;
    logic [2:0] code2;

    logic       bit_valid, bit_out, locked, err_pulse;
    logic [7:0] shift_reg, bit_count, err_count;

    logic       bit_valid2, bit_out2, locked2, err_pulse2;
    logic [7:0] shift_reg2, bit_count2;
    logic [1:0] err_count2;

    typedef struct {
        logic       w;
        logic       bv;
        logic       bo;
        logic       lk;
        logic       ep;
        logic [7:0] sr;
        logic [7:0] bc;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    fsm_code_decoder #(.LOCK_CNT(3), .SHIFT_W(8), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
        .bit_valid(bit_valid), .bit_out(bit_out), .shift_reg(shift_reg),
        .bit_count(bit_count), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    fsm_code_decoder #(.LOCK_CNT(3), .SHIFT_W(8), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .code(code2),
        .bit_valid(bit_valid2), .bit_out(bit_out2), .shift_reg(shift_reg2),
        .bit_count(bit_count2), .locked(locked2), .err_pulse(err_pulse2),
        .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per clock and compares the DUT.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (!e.w) begin
                chk("bit_valid", {7'd0, bit_valid}, {7'd0, e.bv});
                chk("bit_out",   {7'd0, bit_out},   {7'd0, e.bo});
                chk("locked",    {7'd0, locked},    {7'd0, e.lk});
                chk("err_pulse", {7'd0, err_pulse}, {7'd0, e.ep});
                chk("shift_reg", shift_reg, e.sr);
                chk("bit_count", bit_count, e.bc);
                chk("err_count", err_count, e.ec);
            end else begin
                chk("sat_locked",    {7'd0, locked2},    {7'd0, e.lk});
                chk("sat_err_pulse", {7'd0, err_pulse2}, {7'd0, e.ep});
                chk("sat_err_count", {6'd0, err_count2}, e.ec);
                chk("sat_bit_count", bit_count2, e.bc);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [2:0] c,
                        input logic w, input logic bv, input logic bo,
                        input logic lk, input logic ep,
                        input logic [7:0] sr, input logic [7:0] bc,
                        input logic [7:0] ec);
        exp_t e;
        reset = r;
        if (w) begin
            in_valid  = 1'b0;
            in_valid2 = v;
            code2     = c;
        end else begin
            in_valid2 = 1'b0;
            in_valid  = v;
            code      = c;
        end
        @(posedge clk);
        e.w = w; e.bv = bv; e.bo = bo; e.lk = lk; e.ep = ep;
        e.sr = sr; e.bc = bc; e.ec = ec;
        q.push_back(e);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        code      = 3'd0;
        in_valid2 = 1'b0;
        code2     = 3'd0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        // acquire lock: 2,4,6,7 then decode 2,4,1,6,7,4
        step(0, 1, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 4, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 6, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 7, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        step(0, 1, 2, 0, 1, 1, 1, 0, 8'h01, 1, 0);
        step(0, 1, 4, 0, 0, 1, 1, 0, 8'h01, 1, 0);
        step(0, 1, 1, 0, 1, 0, 1, 0, 8'h02, 2, 0);
        step(0, 1, 6, 0, 0, 0, 1, 0, 8'h02, 2, 0);
        step(0, 1, 7, 0, 0, 0, 1, 0, 8'h02, 2, 0);
        step(0, 1, 4, 0, 1, 0, 1, 0, 8'h04, 3, 0);
        // illegal code while locked, then relock
        step(0, 1, 3, 0, 0, 0, 0, 1, 8'h04, 3, 1);
        step(0, 1, 2, 0, 0, 0, 0, 0, 8'h04, 3, 1);
        step(0, 1, 4, 0, 0, 0, 0, 0, 8'h04, 3, 1);
        step(0, 1, 6, 0, 0, 0, 0, 0, 8'h04, 3, 1);
        step(0, 1, 7, 0, 0, 0, 1, 0, 8'h04, 3, 1);
        // bring prev to 2, then illegal transition 2->6
        step(0, 1, 2, 0, 1, 1, 1, 0, 8'h09, 4, 1);
        step(0, 1, 6, 0, 0, 1, 0, 1, 8'h09, 4, 2);
        // TRACK: 7,2,4 relock, no bits during TRACK
        step(0, 1, 7, 0, 0, 1, 0, 0, 8'h09, 4, 2);
        step(0, 1, 2, 0, 0, 1, 0, 0, 8'h09, 4, 2);
        step(0, 1, 4, 0, 0, 1, 1, 0, 8'h09, 4, 2);
        // in_valid gaps with an illegal code on the bus
        for (int i = 0; i < 5; i++)
            step(0, 0, 3, 0, 0, 1, 1, 0, 8'h09, 4, 2);
        step(0, 1, 6, 0, 1, 1, 1, 0, 8'h13, 5, 2);
        step(0, 1, 7, 0, 0, 1, 1, 0, 8'h13, 5, 2);
        step(0, 1, 4, 0, 1, 0, 1, 0, 8'h26, 6, 2);
        step(0, 1, 1, 0, 1, 0, 1, 0, 8'h4C, 7, 2);
        // reset mid-stream with a valid code present
        step(1, 1, 7, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 8'h00, 0, 1);
        // saturation on the ERR_W=2 instance
        step(0, 1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 1);
        step(0, 1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 2);
        step(0, 1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 3);
        step(0, 1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 3);
        step(0, 1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 3);
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 3);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
